// File: rtl/multiplicador_7bit.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock, 2N-bit registered product.
// Optional macro MULTIPLICADOR_SUMANDO_EN adds a sumando port so producto = A*B + sumando.
module multiplicador_7bit #(
    parameter int N = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     multiplicando,
    input  logic [N-1:0]     multiplicador,
`ifdef MULTIPLICADOR_SUMANDO_EN
    input  logic [N-1:0]     sumando,
`endif
    output logic [2*N-1:0]   producto,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [N-1:0]     mcand_q,    mcand_d;
    logic [N:0]       acc_hi_q,   acc_hi_d;
    logic [N-1:0]     mq_q,       mq_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [2*N-1:0]   producto_q, producto_d;
    logic             done_q,     done_d;
    logic             busy_q,     busy_d;

    logic [N:0]       acc_init;
    logic [N:0]       sum;
    logic [2*N:0]     shift_w;
    logic [N:0]       acc_hi_next;
    logic [N-1:0]     mq_next;

`ifdef MULTIPLICADOR_SUMANDO_EN
    assign acc_init = {1'b0, sumando};
`else
    assign acc_init = '0;
`endif

    // One shift-and-add step: the carry of sum lands in the MSB of the shifted acc_hi.
    always_comb begin
        sum         = acc_hi_q + (mq_q[0] ? {1'b0, mcand_q} : '0);
        shift_w     = {1'b0, sum, mq_q[N-1:1]};
        acc_hi_next = shift_w[2*N:N];
        mq_next     = shift_w[N-1:0];
    end

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        acc_hi_d   = acc_hi_q;
        mq_d       = mq_q;
        cnt_d      = cnt_q;
        producto_d = producto_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = multiplicando;
                    mq_d     = multiplicador;
                    acc_hi_d = acc_init;
                    cnt_d    = CW'(N);
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_hi_d = acc_hi_next;
                mq_d     = mq_next;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    producto_d = {acc_hi_next[N-1:0], mq_next};
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            acc_hi_q   <= '0;
            mq_q       <= '0;
            cnt_q      <= '0;
            producto_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            acc_hi_q   <= acc_hi_d;
            mq_q       <= mq_d;
            cnt_q      <= cnt_d;
            producto_q <= producto_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign producto = producto_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_multiplicador_7bit.sv
// Self-checking bench for multiplicador_7bit: vector table, handshake corner cases and randomized ops
// against an arithmetic reference model. Build with MULTIPLICADOR_SUMANDO_EN to cover the addend.
module tb_multiplicador_7bit;

    localparam int N = 7;
`ifdef MULTIPLICADOR_SUMANDO_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   multiplicando;
    logic [N-1:0]   multiplicador;
    logic [N-1:0]   sumando;
    logic [2*N-1:0] producto;
    logic           done;
    logic           busy;

    int checks;
    int errors;

    multiplicador_7bit #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
`ifdef MULTIPLICADOR_SUMANDO_EN
        .sumando       (sumando),
`endif
        .producto      (producto),
        .done          (done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int s;
        int exp;
    } vec_t;

    function automatic int model(input int a, input int b, input int s);
        return a * b + (SUM_EN ? s : 0);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Full operation: accept, count cycles until done, check result, pulse width and hold.
    task automatic run_op(input string name, input int a, input int b, input int s, input int exp);
        int lat;
        @(negedge clk);
        multiplicando = N'(a);
        multiplicador = N'(b);
        sumando       = N'(s);
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        multiplicando = N'($urandom);
        multiplicador = N'($urandom);
        sumando       = N'($urandom);
        chk({name, " busy_after_accept"}, int'(busy), 1);
        lat = 0;
        for (int k = 1; k <= N + 4; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) begin
                chk({name, " busy_during_calc"}, 0, 1);
                break;
            end
        end
        chk({name, " latency"}, lat, N);
        chk({name, " busy_at_done"}, int'(busy), 0);
        chk({name, " producto"}, int'(producto), exp);
        @(negedge clk);
        chk({name, " done_one_cycle"}, int'(done), 0);
        repeat (2) @(negedge clk);
        chk({name, " producto_hold"}, int'(producto), exp);
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        int seen_done;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        multiplicando = '0;
        multiplicador = '0;
        sumando = '0;

        vecs.push_back('{10, 5, 0, 50});
        vecs.push_back('{127, 127, 0, 16129});
        vecs.push_back('{0, 99, 0, 0});
        vecs.push_back('{6, 7, 0, 42});
        vecs.push_back('{1, 1, 0, 1});
        vecs.push_back('{127, 1, 0, 127});
        vecs.push_back('{64, 2, 0, 128});
        if (SUM_EN) begin
            vecs.push_back('{14, 7, 2, 100});
            vecs.push_back('{42, 3, 1, 127});
            vecs.push_back('{127, 127, 127, 16256});
            vecs.push_back('{0, 0, 127, 127});
        end

        repeat (2) @(negedge clk);
        chk("reset producto", int'(producto), 0);
        chk("reset done", int'(done), 0);
        chk("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", int'(busy), 0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);

        // start held through CALC and DONE: operands changed mid-op must not be picked up.
        @(negedge clk);
        multiplicando = 7'd3;
        multiplicador = 7'd4;
        start = 1'b1;
        @(negedge clk);
        multiplicando = 7'd9;
        multiplicador = 7'd9;
        sumando = '0;
        repeat (N) @(negedge clk);
        chk("held done1", int'(done), 1);
        chk("held prod1", int'(producto), 12);
        @(negedge clk);
        chk("held idle_gap busy", int'(busy), 0);
        chk("held idle_gap done", int'(done), 0);
        @(negedge clk);
        chk("held reaccept busy", int'(busy), 1);
        start = 1'b0;
        repeat (N) @(negedge clk);
        chk("held done2", int'(done), 1);
        chk("held prod2", int'(producto), 81);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        multiplicando = 7'd100;
        multiplicador = 7'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort producto", int'(producto), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        chk("abort no_done", seen_done, 0);
        run_op("after_abort", 6, 7, 0, 42);

        // Divider round trip: Q*B + R reconstructs the dividend when the addend is present.
        begin
            int dvd[3] = '{50, 100, 127};
            int dvs[3] = '{5, 7, 3};
            for (int i = 0; i < 3; i++) begin
                int q, r;
                q = dvd[i] / dvs[i];
                r = dvd[i] % dvs[i];
                run_op($sformatf("div%0d", i), q, dvs[i], r, SUM_EN ? dvd[i] : dvd[i] - r);
            end
        end

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 25; i++) begin
            int a, b, s;
            a = int'($urandom_range(0, 127));
            b = int'($urandom_range(0, 127));
            s = int'($urandom_range(0, 127));
            run_op($sformatf("rnd%0d a=%0d b=%0d s=%0d", i, a, b, s), a, b, s, model(a, b, s));
        end

        lat = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
